l2_req_scheduler: RTL and testbench

L2_REQ_SCHEDULER -- requirements
Module: l2_req_scheduler

---
 rtl/mempool_pkg.sv | 6 +
 rtl/fifo_v3.sv | 79 +++++++
 rtl/l2_req_scheduler.sv | 157 +++++++++++++++
 tb/tb_l2_req_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mempool_pkg.sv
// Shared MemPool system constants.
package mempool_pkg;

    localparam int unsigned AddrWidth = 32;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO. Pushes are ignored when full and pops are ignored when empty.
// The two never bypass each other, so a freed slot is only visible on the next cycle.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned CntW = ADDR_DEPTH + 1;

    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // With a power-of-two depth the full count wraps to zero here; full_o carries the MSB.
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d = (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/l2_req_scheduler.sv
// Round-robin scheduler funnelling NumReq requesters onto one in-order L2 port and
// routing responses back through a queue of granted requester indices.
module l2_req_scheduler
    import mempool_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned DataWidth      = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]        req_addr_i,
    input  logic [NumReq-1:0]                  req_we_i,
    output logic                               l2_valid_o,
    input  logic                               l2_ready_i,
    output logic [AddrWidth-1:0]               l2_addr_o,
    output logic                               l2_we_o,
    input  logic                               l2_rvalid_i,
    output logic                               l2_rready_o,
    input  logic [DataWidth-1:0]               l2_rdata_i,
    output logic [NumReq-1:0]                  rsp_valid_o,
    input  logic [NumReq-1:0]                  rsp_ready_i,
    output logic [DataWidth-1:0]               rsp_data_o,
    output logic [$clog2(MaxOutstanding):0]    outstanding_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {StIdle, StLocked} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   grant_q, grant_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   grant, arb_idx, head;
    logic              arb_valid, issue, hs, pop, spurious;
    logic              spurious_q, spurious_d;
    logic              q_full, q_empty;
    logic [$clog2(MaxOutstanding)-1:0] q_usage;

    // Round-robin search starting at the pointer.
    always_comb begin
        int unsigned cand;
        cand      = 0;
        arb_valid = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NumReq) cand = cand - NumReq;
            if (!arb_valid && req_valid_i[IdxW'(cand)]) begin
                arb_valid = 1'b1;
                arb_idx   = IdxW'(cand);
            end
        end
    end

    // Grant FSM: issue in the same cycle a request is seen, lock the grant if L2 stalls.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        grant   = '0;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arb_valid && !q_full) begin
                    issue = 1'b1;
                    grant = arb_idx;
                    if (!l2_ready_i) begin
                        state_d = StLocked;
                        grant_d = arb_idx;
                    end
                end
            end
            StLocked: begin
                issue = 1'b1;
                grant = grant_q;
                if (l2_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (rst_i) issue = 1'b0;
        hs = issue & l2_ready_i;
        if (hs) ptr_d = (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
    end

    // Request-side outputs; only the granted requester ever sees ready.
    always_comb begin
        req_ready_o = '0;
        l2_addr_o   = '0;
        l2_valid_o  = issue;
        l2_we_o     = issue & req_we_i[grant];
        if (hs) req_ready_o[grant] = 1'b1;
        for (int unsigned g = 0; g < NumReq; g++) begin
            if (issue && grant == IdxW'(g)) l2_addr_o = req_addr_i[g*AddrWidth +: AddrWidth];
        end
    end

    // Response routing to the oldest outstanding requester; strays are swallowed.
    always_comb begin
        rsp_valid_o = '0;
        l2_rready_o = 1'b0;
        pop         = 1'b0;
        spurious    = 1'b0;
        if (!rst_i) begin
            if (q_empty) begin
                l2_rready_o = 1'b1;
                spurious    = l2_rvalid_i;
            end else begin
                l2_rready_o       = rsp_ready_i[head];
                rsp_valid_o[head] = l2_rvalid_i;
                pop               = l2_rvalid_i & rsp_ready_i[head];
            end
        end
        spurious_d = spurious_q | spurious;
    end

    assign rsp_data_o    = l2_rdata_i;
    assign outstanding_o = {q_full, q_usage};

    // State, grant, pointer and sticky stray-response flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            spurious_q <= spurious_d;
        end
    end

    // A response with nothing outstanding is a protocol violation by the L2 side.
    assert property (@(posedge clk_i) disable iff (rst_i) !spurious_q);

    // Reset flushes the queue synchronously, so the asynchronous reset is unused.
    fifo_v3 #(
        .DATA_WIDTH (IdxW),
        .DEPTH      (MaxOutstanding)
    ) i_src_queue (
        .clk_i   (clk_i),
        .rst_ni  (1'b1),
        .flush_i (rst_i),
        .full_o  (q_full),
        .empty_o (q_empty),
        .usage_o (q_usage),
        .data_i  (grant),
        .push_i  (hs),
        .data_o  (head),
        .pop_i   (pop)
    );

endmodule

// File: tb/tb_l2_req_scheduler.sv
// Directed bench for l2_req_scheduler with NumReq=4, MaxOutstanding=8, DataWidth=64.
module tb_l2_req_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_valid_i;
    logic [3:0]  req_ready_o;
    logic [127:0] req_addr_i;
    logic [3:0]  req_we_i;
    logic        l2_valid_o, l2_ready_i;
    logic [31:0] l2_addr_o;
    logic        l2_we_o;
    logic        l2_rvalid_i, l2_rready_o;
    logic [63:0] l2_rdata_i;
    logic [3:0]  rsp_valid_o, rsp_ready_i;
    logic [63:0] rsp_data_o;
    logic [3:0]  outstanding_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_i = ~clk_i;

    l2_req_scheduler #(
        .NumReq         (4),
        .MaxOutstanding (8),
        .DataWidth      (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_addr_i    (req_addr_i),
        .req_we_i      (req_we_i),
        .l2_valid_o    (l2_valid_o),
        .l2_ready_i    (l2_ready_i),
        .l2_addr_o     (l2_addr_o),
        .l2_we_o       (l2_we_o),
        .l2_rvalid_i   (l2_rvalid_i),
        .l2_rready_o   (l2_rready_o),
        .l2_rdata_i    (l2_rdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .outstanding_o (outstanding_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i % 4] = 1'b1;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) req_addr_i[i*32 +: 32] = addr_of(i);
        req_we_i    = 4'b0101;
        rst_i       = 1'b1;
        req_valid_i = 4'hF;
        l2_ready_i  = 1'b1;
        l2_rvalid_i = 1'b1;
        l2_rdata_i  = '0;
        rsp_ready_i = 4'hF;

        // Reset: everything quiet even with traffic on the inputs.
        tick();
        tick();
        #1;
        check("rst_l2_valid", l2_valid_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_l2_rready", l2_rready_o, 0);
        check("rst_outstanding", outstanding_o, 0);

        // All four valid, L2 always ready: grants 0,1,2,3,0 back to back.
        rst_i       = 1'b0;
        l2_rvalid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_ready", req_ready_o, onehot(i));
            check("rr_addr", l2_addr_o, addr_of(i % 4));
            check("rr_we", l2_we_o, req_we_i[i % 4]);
            tick();
        end
        req_valid_i = 4'h0;
        #1;
        check("rr_outstanding", outstanding_o, 5);
        check("rr_idle_valid", l2_valid_o, 0);

        // Drain in grant order.
        l2_rvalid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            l2_rdata_i = 64'hD000 + 64'(i);
            #1;
            check("drain_rsp_valid", rsp_valid_o, onehot(i));
            check("drain_rsp_data", rsp_data_o, 64'hD000 + 64'(i));
            check("drain_rready", l2_rready_o, 1);
            tick();
        end
        l2_rvalid_i = 1'b0;
        #1;
        check("drain_outstanding", outstanding_o, 0);

        // Lock: requester 2 held through a stall while requester 0 arrives.
        req_valid_i = 4'b0100;
        l2_ready_i  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) req_valid_i = 4'b0101;
            #1;
            check("lock_valid", l2_valid_o, 1);
            check("lock_addr", l2_addr_o, addr_of(2));
            check("lock_ready", req_ready_o, 0);
            tick();
        end
        l2_ready_i = 1'b1;
        #1;
        check("lock_hs", req_ready_o, 4'b0100);
        tick();
        req_valid_i = 4'b0001;
        #1;
        check("lock_next", req_ready_o, 4'b0001);
        check("lock_next_addr", l2_addr_o, addr_of(0));
        tick();
        req_valid_i = 4'b0000;

        // Response backpressure on head requester 2.
        l2_rvalid_i = 1'b1;
        l2_rdata_i  = 64'hBEEF;
        rsp_ready_i = 4'b1011;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_rsp_valid", rsp_valid_o, 4'b0100);
            check("bp_rready", l2_rready_o, 0);
            check("bp_data", rsp_data_o, 64'hBEEF);
            check("bp_outstanding", outstanding_o, 2);
            tick();
        end
        rsp_ready_i = 4'hF;
        #1;
        check("bp_release", l2_rready_o, 1);
        tick();
        l2_rdata_i = 64'hC0;
        #1;
        check("bp_after_pop", outstanding_o, 1);
        check("bp_next_head", rsp_valid_o, 4'b0001);
        tick();
        l2_rvalid_i = 1'b0;
        #1;
        check("bp_empty", outstanding_o, 0);

        // Grants 3,1,0; the grant of 0 coincides with the first response.
        req_valid_i = 4'b1000;
        #1;
        check("ord_g3", req_ready_o, 4'b1000);
        tick();
        req_valid_i = 4'b0010;
        #1;
        check("ord_g1", req_ready_o, 4'b0010);
        tick();
        req_valid_i = 4'b0001;
        l2_rvalid_i = 1'b1;
        l2_rdata_i  = 64'hD0;
        #1;
        check("ord_g0", req_ready_o, 4'b0001);
        check("ord_r0_valid", rsp_valid_o, 4'b1000);
        check("ord_r0_data", rsp_data_o, 64'hD0);
        tick();
        req_valid_i = 4'b0000;
        l2_rdata_i  = 64'hD1;
        #1;
        check("ord_push_pop_cnt", outstanding_o, 2);
        check("ord_r1_valid", rsp_valid_o, 4'b0010);
        check("ord_r1_data", rsp_data_o, 64'hD1);
        tick();
        l2_rdata_i = 64'hD2;
        #1;
        check("ord_r2_valid", rsp_valid_o, 4'b0001);
        check("ord_r2_data", rsp_data_o, 64'hD2);
        tick();
        l2_rvalid_i = 1'b0;
        #1;
        check("ord_empty", outstanding_o, 0);

        // Fill to MaxOutstanding, then free one slot.
        req_valid_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("fill_ready", req_ready_o, onehot(i + 1));
            tick();
        end
        #1;
        check("full_cnt", outstanding_o, 8);
        check("full_valid", l2_valid_o, 0);
        check("full_ready", req_ready_o, 0);
        tick();
        check("full_hold", outstanding_o, 8);
        l2_rvalid_i = 1'b1;
        l2_rdata_i  = 64'hE1;
        #1;
        check("full_pop_no_bypass", l2_valid_o, 0);
        check("full_pop_head", rsp_valid_o, 4'b0010);
        check("full_pop_rready", l2_rready_o, 1);
        tick();
        l2_rvalid_i = 1'b0;
        #1;
        check("refill_cnt", outstanding_o, 7);
        check("refill_valid", l2_valid_o, 1);
        check("refill_ready", req_ready_o, 4'b0010);
        tick();
        #1;
        check("refull_cnt", outstanding_o, 8);
        check("refull_valid", l2_valid_o, 0);

        // Pop three, leaving five outstanding, then reset mid-flight.
        req_valid_i = 4'h0;
        l2_rvalid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("pre_rst_head", rsp_valid_o, onehot(i + 2));
            tick();
        end
        l2_rvalid_i = 1'b0;
        #1;
        check("pre_rst_cnt", outstanding_o, 5);
        rst_i       = 1'b1;
        req_valid_i = 4'hF;
        l2_rvalid_i = 1'b1;
        #1;
        check("mid_rst_valid", l2_valid_o, 0);
        check("mid_rst_ready", req_ready_o, 0);
        check("mid_rst_rsp", rsp_valid_o, 0);
        check("mid_rst_rready", l2_rready_o, 0);
        tick();
        check("post_rst_cnt", outstanding_o, 0);
        rst_i       = 1'b0;
        l2_rvalid_i = 1'b0;
        #1;
        check("post_rst_ptr", req_ready_o, 4'b0001);
        tick();
        req_valid_i = 4'h0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
